// File: rtl/operand_fifo_if.sv
// Operand handshake bundle: upstream push side and downstream pop side.
interface operand_fifo_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic       out_ready;
    logic       out_e;
    logic [3:0] out_a;
    logic [3:0] out_b;
    logic [2:0] out_op;

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_e, out_a, out_b, out_op
    );

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_e, out_a, out_b, out_op
    );
endinterface

// File: rtl/operand_fifo.sv
// Operand/opcode FIFO feeding the ALU operand-gating stage.
// Head outputs are forced to zero whenever the FIFO is empty.
module operand_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    operand_fifo_if.slave            bus,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clr_err,
    output logic                     drop_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [10:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_drop_err;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [10:0]   w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid & bus.in_ready;
    assign w_pop   = bus.out_e & bus.out_ready;
    assign w_head  = r_mem[r_rd_ptr];

    // rst_n gates in_ready so it drops the instant reset asserts
    assign bus.in_ready = rst_n & ~w_full;
    assign bus.out_e    = ~w_empty;
    assign bus.out_a    = bus.out_e ? w_head[10:7] : 4'd0;
    assign bus.out_b    = bus.out_e ? w_head[6:3]  : 4'd0;
    assign bus.out_op   = bus.out_e ? w_head[2:0]  : 3'd0;

    assign count    = r_count;
    assign drop_err = r_drop_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_a, bus.in_b, bus.in_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A refused offer in the same cycle as clr_err keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_err <= 1'b0;
        end else if (bus.in_valid & ~bus.in_ready) begin
            r_drop_err <= 1'b1;
        end else if (clr_err) begin
            r_drop_err <= 1'b0;
        end
    end
endmodule
